// File: rtl/pwm_multi_ch.sv
// Centre-aligned multi-channel PWM: one shared up/down carrier, per-channel duty
// comparators with complementary dead-banded outputs and double-buffered settings.
module pwm_multi_ch #(
    parameter int N_CH     = 3,
    parameter int WIDTH    = 16,
    parameter int DT_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      period,
    input  logic [N_CH*WIDTH-1:0] duty,
    input  logic [DT_WIDTH-1:0]   dead_time,
    input  logic                  load_mode,
    input  logic                  update_lock,
    input  logic [N_CH-1:0]       enable,
    input  logic                  valley_trig_en,
    input  logic                  peak_trig_en,
    output logic [N_CH-1:0]       pwm_h,
    output logic [N_CH-1:0]       pwm_l,
    output logic                  valley_trig,
    output logic                  peak_trig
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    localparam logic [WIDTH-1:0]    CNT_ONE = WIDTH'(1);
    localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);
    localparam logic [DT_WIDTH-1:0] DT_MAX  = '1;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    dir_e                dir_q, dir_d;
    logic                valley_next, peak_next;
    logic                load_all, load_duty, carrier_on;
    logic                valley_trig_q, valley_trig_d;
    logic                peak_trig_q, peak_trig_d;

    assign carrier_on = (period_q != '0);

    always_comb begin
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        valley_next = 1'b0;
        peak_next   = 1'b0;
        if (!carrier_on) begin
            // A zero period parks the carrier at the valley and reloads every cycle.
            cnt_d       = '0;
            dir_d       = DIR_UP;
            valley_next = 1'b1;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == period_q - CNT_ONE) begin
                cnt_d     = period_q;
                dir_d     = DIR_DOWN;
                peak_next = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            if (cnt_q == CNT_ONE) begin
                cnt_d       = '0;
                dir_d       = DIR_UP;
                valley_next = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    assign load_all  = valley_next & ~update_lock;
    assign load_duty = load_all | (peak_next & load_mode & ~update_lock);

    always_comb begin
        period_d      = load_all ? period : period_q;
        dt_d          = load_all ? dead_time : dt_q;
        valley_trig_d = valley_trig_en & carrier_on & (dir_q == DIR_UP) & (cnt_q == '0);
        peak_trig_d   = peak_trig_en & carrier_on & (dir_q == DIR_DOWN) & (cnt_q == period_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            dir_q         <= DIR_UP;
            period_q      <= period;
            dt_q          <= dead_time;
            valley_trig_q <= 1'b0;
            peak_trig_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            period_q      <= period_d;
            dt_q          <= dt_d;
            valley_trig_q <= valley_trig_d;
            peak_trig_q   <= peak_trig_d;
        end
    end

    assign valley_trig = valley_trig_q;
    assign peak_trig   = peak_trig_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0]    duty_q, duty_d;
            logic [DT_WIDTH-1:0] db_q, db_d;
            logic                raw, raw_r_q;
            logic                dt_done, h_q, h_d, l_q, l_d;

            always_comb begin
                duty_d = load_duty ? duty[gi*WIDTH +: WIDTH] : duty_q;
                raw    = 1'b0;
                if (carrier_on) begin
                    raw = (dir_q == DIR_UP) ? (cnt_q < duty_q) : (cnt_q <= duty_q);
                end
                // Counter reads 0 in the first cycle raw_r_q holds its new value.
                if (raw != raw_r_q) begin
                    db_d = '0;
                end else if (db_q != DT_MAX) begin
                    db_d = db_q + DT_ONE;
                end else begin
                    db_d = db_q;
                end
                dt_done = (db_q >= dt_q);
                h_d     = raw_r_q & dt_done;
                l_d     = ~raw_r_q & dt_done;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    duty_q  <= duty[gi*WIDTH +: WIDTH];
                    raw_r_q <= 1'b0;
                    db_q    <= '0;
                    h_q     <= 1'b0;
                    l_q     <= 1'b0;
                end else begin
                    duty_q  <= duty_d;
                    raw_r_q <= raw;
                    db_q    <= db_d;
                    h_q     <= h_d;
                    l_q     <= l_d;
                end
            end

            assign pwm_h[gi] = h_q & enable[gi];
            assign pwm_l[gi] = l_q & enable[gi];
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: vector table, hand-written corner sequences and random
// stimulus, all checked every cycle against a carrier-position reference model.
module tb_pwm_multi_ch;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int DTW = 10;
    localparam int HD  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   period_v;
    logic [N*W-1:0] duty_v;
    logic [DTW-1:0] dt_v;
    logic           load_mode_v, lock_v, vten_v, pten_v;
    logic [N-1:0]   en_v;
    logic [N-1:0]   pwm_h_w, pwm_l_w;
    logic           vt_w, pt_w;

    pwm_multi_ch #(.N_CH(N), .WIDTH(W), .DT_WIDTH(DTW)) dut (
        .clk(clk), .reset(rst), .period(period_v), .duty(duty_v), .dead_time(dt_v),
        .load_mode(load_mode_v), .update_lock(lock_v), .enable(en_v),
        .valley_trig_en(vten_v), .peak_trig_en(pten_v),
        .pwm_h(pwm_h_w), .pwm_l(pwm_l_w), .valley_trig(vt_w), .peak_trig(pt_w)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: carrier described by position within a 2*Ps carrier.
    int m_pos, m_ps, m_dt;
    int m_ds [N];
    bit m_h [N];
    bit m_l [N];
    bit m_vt, m_pt;
    bit hist [N][HD];
    int hcnt [N];

    typedef struct {
        int p; int d; int dt; int eh; int el;
    } vec_t;
    vec_t vecs [9];

    int seq_h [9]  = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
    int seq_l [9]  = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
    int seq_vt [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    int seq_pt [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s cyc=%0d: timed out waiting for DUT event", name, cyc);
    endtask

    task automatic model_step();
        int  nxt;
        bit  rawr, stable;
        bit  raw_now [N];
        if (rst) begin
            m_pos = 0;
            m_ps  = int'(period_v);
            m_dt  = int'(dt_v);
            for (int i = 0; i < N; i++) begin
                m_ds[i] = int'(duty_v[i*W +: W]);
                for (int k = 0; k < HD; k++) hist[i][k] = 1'b0;
                hcnt[i] = 1;
                m_h[i]  = 1'b0;
                m_l[i]  = 1'b0;
            end
            m_vt = 1'b0;
            m_pt = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            // Output side is on only if raw_r has been steady for dead_time+1 cycles.
            rawr   = hist[i][0];
            stable = (hcnt[i] > m_dt);
            for (int k = 0; k <= m_dt && k < HD; k++)
                if (hist[i][k] != rawr) stable = 1'b0;
            m_h[i] = rawr & stable;
            m_l[i] = ~rawr & stable;
            if (m_ps == 0) raw_now[i] = 1'b0;
            else if (m_pos < m_ps) raw_now[i] = (m_pos < m_ds[i]);
            else raw_now[i] = ((2 * m_ps - m_pos) <= m_ds[i]);
        end
        m_vt = (m_ps != 0) && (m_pos == 0) && vten_v;
        m_pt = (m_ps != 0) && (m_pos == m_ps) && pten_v;
        nxt  = (m_ps == 0) ? 0 : (m_pos + 1) % (2 * m_ps);
        if (!lock_v) begin
            if (nxt == 0) begin
                m_ps = int'(period_v);
                m_dt = int'(dt_v);
                for (int i = 0; i < N; i++) m_ds[i] = int'(duty_v[i*W +: W]);
            end else if (load_mode_v && nxt == m_ps) begin
                for (int i = 0; i < N; i++) m_ds[i] = int'(duty_v[i*W +: W]);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int k = HD - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = raw_now[i];
            if (hcnt[i] < HD) hcnt[i]++;
        end
        m_pos = nxt;
    endtask

    task automatic check_all();
        logic [N-1:0] eh, el;
        for (int i = 0; i < N; i++) begin
            eh[i] = m_h[i] & en_v[i];
            el[i] = m_l[i] & en_v[i];
        end
        chk("pwm_h", int'(pwm_h_w), int'(eh));
        chk("pwm_l", int'(pwm_l_w), int'(el));
        chk("valley_trig", int'(vt_w), int'(m_vt));
        chk("peak_trig", int'(pt_w), int'(m_pt));
        chk("overlap", int'(|(pwm_h_w & pwm_l_w)), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic set_duty(input int ch, input int d);
        duty_v[ch*W +: W] = W'(d);
    endtask

    task automatic set_duty_all(input int d);
        for (int i = 0; i < N; i++) set_duty(i, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic measure_h0(output int len);
        int t = 0;
        len = 0;
        while (pwm_h_w[0] !== 1'b1 && t < 80) begin
            tick();
            t++;
        end
        if (t >= 80) begin
            fail_timeout("h0_rise");
            return;
        end
        while (pwm_h_w[0] === 1'b1 && len < 80) begin
            tick();
            len++;
        end
    endtask

    task automatic wait_vt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (vt_w !== 1'b1 && n < 60);
        if (n >= 60) fail_timeout("valley_trig");
    endtask

    task automatic setup(input int p, input int d, input int dt);
        period_v    = W'(p);
        set_duty_all(d);
        dt_v        = DTW'(dt);
        load_mode_v = 1'b0;
        lock_v      = 1'b0;
        en_v        = '1;
        vten_v      = 1'b1;
        pten_v      = 1'b1;
    endtask

    initial begin
        int hc, lc, vc, pc, len, n;
        rst = 1'b1;
        setup(4, 2, 0);

        vecs[0] = '{p:4,  d:2, dt:0, eh:4, el:4};
        vecs[1] = '{p:4,  d:0, dt:0, eh:0, el:8};
        vecs[2] = '{p:4,  d:4, dt:0, eh:8, el:0};
        vecs[3] = '{p:4,  d:9, dt:0, eh:8, el:0};
        vecs[4] = '{p:10, d:5, dt:3, eh:7, el:7};
        vecs[5] = '{p:10, d:1, dt:3, eh:0, el:15};
        vecs[6] = '{p:6,  d:3, dt:1, eh:5, el:5};
        vecs[7] = '{p:1,  d:1, dt:0, eh:2, el:0};
        vecs[8] = '{p:3,  d:2, dt:2, eh:2, el:0};

        // Steady-state high/low counts over one full carrier.
        for (int v = 0; v < 9; v++) begin
            setup(vecs[v].p, vecs[v].d, vecs[v].dt);
            do_reset();
            repeat (10 * vecs[v].p + vecs[v].dt + 8) tick();
            hc = 0; lc = 0; vc = 0;
            repeat (2 * vecs[v].p) begin
                tick();
                hc += int'(pwm_h_w[0]);
                lc += int'(pwm_l_w[0]);
                vc += int'(vt_w);
            end
            chk($sformatf("vec%0d_high", v), hc, vecs[v].eh);
            chk($sformatf("vec%0d_low", v), lc, vecs[v].el);
            chk($sformatf("vec%0d_vtrig", v), vc, 1);
        end

        // Basic carrier, cycle-exact from reset release.
        setup(4, 2, 0);
        do_reset();
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("basic_h_c%0d", c + 1), int'(pwm_h_w[0]), seq_h[c]);
            chk($sformatf("basic_l_c%0d", c + 1), int'(pwm_l_w[0]), seq_l[c]);
            chk($sformatf("basic_vt_c%0d", c + 1), int'(vt_w), seq_vt[c]);
            chk($sformatf("basic_pt_c%0d", c + 1), int'(pt_w), seq_pt[c]);
        end

        // Duty change mid up-phase: valley load, peak load, locked.
        for (int mode = 0; mode < 3; mode++) begin
            setup(8, 2, 0);
            load_mode_v = (mode == 1);
            do_reset();
            repeat (4) tick();
            lock_v = (mode == 2);
            set_duty(0, 6);
            measure_h0(len);
            chk($sformatf("shadow_mode%0d_pulse", mode), len, (mode == 0) ? 8 : (mode == 1) ? 12 : 4);
            lock_v = 1'b0;
        end

        // Period change mid-carrier, then zero period.
        setup(8, 2, 0);
        do_reset();
        tick();
        chk("period_first_vt", int'(vt_w), 1);
        repeat (3) tick();
        period_v = 16'd3;
        wait_vt(n);
        chk("period_old_carrier", n + 3, 16);
        wait_vt(n);
        chk("period_new_carrier1", n, 6);
        wait_vt(n);
        chk("period_new_carrier2", n, 6);
        period_v = 16'd0;
        dt_v     = 10'd2;
        repeat (12) tick();
        vc = 0; pc = 0;
        repeat (20) begin
            tick();
            vc += int'(vt_w);
            pc += int'(pt_w);
        end
        chk("p0_vtrig_count", vc, 0);
        chk("p0_ptrig_count", pc, 0);
        chk("p0_pwm_h", int'(pwm_h_w), 0);
        chk("p0_pwm_l", int'(pwm_l_w), 7);

        // Reset at cnt=5, then single-channel enable gating.
        setup(8, 2, 0);
        do_reset();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst_pwm_h", int'(pwm_h_w), 0);
        chk("rst_pwm_l", int'(pwm_l_w), 0);
        chk("rst_vt", int'(vt_w), 0);
        rst = 1'b0;
        tick();
        chk("rst_restart_vt", int'(vt_w), 1);
        repeat (10) tick();
        en_v = 3'b101;
        #1;
        chk("en1_off_h", int'(pwm_h_w[1]), 0);
        chk("en1_off_l", int'(pwm_l_w[1]), 0);
        chk("en_ch0_h", int'(pwm_h_w[0]), int'(m_h[0]));
        chk("en_ch0_l", int'(pwm_l_w[0]), int'(m_l[0]));
        chk("en_ch2_h", int'(pwm_h_w[2]), int'(m_h[2]));
        chk("en_ch2_l", int'(pwm_l_w[2]), int'(m_l[2]));
        en_v = 3'b111;
        #1;
        chk("en1_on", int'(pwm_h_w[1] | pwm_l_w[1]), 1);
        tick();

        // Random stimulus against the reference model.
        setup(5, 3, 1);
        do_reset();
        for (int r = 0; r < 2500; r++) begin
            if ($urandom_range(0, 39) == 0) period_v = W'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) set_duty(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 59) == 0) dt_v = DTW'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) load_mode_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) lock_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) en_v = N'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) vten_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) pten_v = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Multi-channel, centre-aligned PWM generator. One shared triangular carrier drives `N_CH` independent duty comparators. Each channel produces a complementary high/low output pair with programmable dead band. Period, duty and dead time are double-buffered in shadow registers, and carrier valley/peak trigger pulses are provided for ADC or control-loop synchronisation. It replaces the single-channel modulator in power-stage designs needing multi-leg inverters.

## Interface
- `N_CH`, default 3: number of channels.
- `WIDTH`, default 16: width of period, duty and carrier counter.
- `DT_WIDTH`, default 10: width of dead-time value and dead-band counters.
- `clk`  input  1  clock. Reset is synchronous, active-high, named `reset`.
- `reset`  input  1  synchronous active-high reset.
- `period`  input  WIDTH  half-carrier length P in clocks. The carrier lasts 2P clocks.
- `duty`  input  N_CH*WIDTH  per-channel duty D. Channel i occupies bits [i*WIDTH +: WIDTH].
- `dead_time`  input  DT_WIDTH  dead band in clocks, common to all channels.
- `load_mode`  input  1  0: duty loads at the valley only. 1: duty loads at valley and peak.
- `update_lock`  input  1  1: shadow registers hold their values and ignore loads.
- `enable`  input  N_CH  per-channel output enable.
- `valley_trig_en`, `peak_trig_en`  input  1 each  trigger enables.
- `pwm_h`, `pwm_l`  output  N_CH each  high-side and low-side gate signals.
- `valley_trig`, `peak_trig`  output  1 each  one-cycle trigger pulses.

## Operation
- **Carrier.** Registers are `cnt` (WIDTH bits) and `dir` (up/down), with shadow period Ps.
  - Up phase: `cnt` counts 0..Ps-1. At Ps-1 the next value is `cnt`=Ps with `dir`=down.
  - Down phase: `cnt` counts Ps..1. At 1 the next value is `cnt`=0 with `dir`=up.
  - Carrier length is exactly 2Ps clocks.
  - Ps=0: `cnt` is held at 0, all raw compares are 0, and no triggers fire.
- **Comparator** (channel i, shadow duty Ds):
  - Up phase: raw = `cnt` < Ds. Down phase: raw = `cnt` <= Ds.
  - High time is 2·min(Ds,Ps) clocks, centred on the valley.
  - Ds=0 gives raw always 0. Ds>=Ps gives raw always 1. No other special cases.
- **Shadow load.** Period, duty and dead time load in the cycle where the next `cnt` is the valley (`cnt`=1 down, or Ps=0). The new values are in effect from `cnt`=0.
  - `load_mode`=1: duty alone also loads where the next `cnt`=Ps (peak). Period and dead time never load at the peak.
  - `update_lock`=1 suppresses all loads.
- **Dead band.**
  - Each channel registers raw into `raw_r`.
  - A saturating DT_WIDTH counter clears to 0 on every change of `raw_r` and otherwise increments.
  - `pwm_h` = `raw_r` and counter >= dead time. `pwm_l` = !`raw_r` and counter >= dead time.
  - Both are registered, then ANDed combinationally with `enable[i]`.
  - A pulse shorter than or equal to the dead time is suppressed entirely.
  - `pwm_h` and `pwm_l` are never both 1.
- **Triggers.** `valley_trig` is registered: it is 1 for one cycle following each cycle with `cnt`=0 in the up phase, ANDed with `valley_trig_en`. `peak_trig` follows the same rule for `cnt`=Ps.
- **Width rule.** All compares are unsigned WIDTH-bit values, with no sums, so there is no overflow. A dead time of 2^DT_WIDTH-1 is the maximum.

## Timing
- **Reset** (synchronous; takes effect at the first edge with `reset`=1):
  - `cnt`=0, `dir`=up.
  - Shadows load directly from the inputs.
  - `raw_r`=0 and dead-band counters are 0.
  - All registered outputs and triggers are 0.
  - Reset mid-carrier aborts the cycle immediately; there is no completion of the current period.
- **First carrier** after reset is released: `cnt`=0 is in the first cycle with `reset`=0.
- **Latency:**
  - Carrier value to `raw_r`: 1 clock.
  - `raw_r` to output register: 1 clock.
  - A comparator edge therefore appears on an output 2 clocks later with a dead time of 0.
  - The rising edge of the newly active side is delayed a further `dead_time` clocks.
- **Counter after a `raw_r` change:** the dead-band counter is 0 in the first cycle after the change, so the active side rises exactly `dead_time` cycles after the other side falls.
- **Input changes:**
  - Duty or period changes outside a load point have no effect until the next load point.
  - A mid-carrier period change never truncates or extends the current carrier.
- **Enable** deasserts the outputs in the same cycle, since it is combinational. Internal state keeps running.

## Test plan
- **Basic carrier:** P=4, D0=2, dead time 0, after reset. Required: `cnt` cycles 0,1,2,3,4,3,2,1; `pwm_h[0]` is high 4 of 8 clocks, centred on the valley; `pwm_l[0]` is its exact complement; `valley_trig` pulses every 8 clocks.
- **Extreme duties:** D=0, D=P and D=P+5. Required: constant low, constant high and constant high respectively, with no glitches across the carrier wrap.
- **Dead band:** P=10, D=5, dead time 3. Required: each output's rising edge lags the other's falling edge by 3 clocks and the outputs never overlap. Then with D=1 and dead time 3 (a 2-clock pulse): `pwm_h` stays 0.
- **Shadow timing:** change D from 2 to 6 mid up-phase with `load_mode`=0. Required: the new duty takes effect at the next valley. Repeat with `load_mode`=1: it takes effect at the next peak. With `update_lock`=1: no change at all.
- **Period change and Ps=0:** change P from 8 to 3 mid-carrier. Required: the current 16-clock carrier completes, then 6-clock carriers follow. With P=0: `cnt` is held at 0, outputs `pwm_h`=0 and `pwm_l`=1 once the dead time elapses, and no triggers fire.
- **Reset and enable:** assert `reset` for 1 cycle at `cnt`=5. Required: all outputs are 0 on the next cycle and the carrier restarts at 0. Toggle `enable[1]` only: channel 1 is gated in the same cycle and channels 0 and 2 are unaffected.
